// File: rtl/cpu_req_scheduler_pkg.sv
// rtl/cpu_req_scheduler_pkg.sv - shared types and constants for the CPU request scheduler
package cpu_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_READ,
        ST_RESP
    } state_e;

    localparam logic [31:0] INSN_NEW_NOTE_DEF = 32'hF8400000;
    localparam logic [9:0]  CHK_OP_DEF        = 10'b1111000010;
    localparam logic [4:0]  NEW_RD_REG_DEF    = 5'd1;
    localparam logic [4:0]  CHK_RD_REG_DEF    = 5'd2;

    // PS/2 set-2 scan codes for the four lane keys
    localparam logic [7:0] KEY_SC_A = 8'h1c;
    localparam logic [7:0] KEY_SC_S = 8'h1b;
    localparam logic [7:0] KEY_SC_D = 8'h23;
    localparam logic [7:0] KEY_SC_F = 8'h2b;

    function automatic logic [31:0] chk_insn(input logic [9:0] op, input logic [9:0] coord);
        return {op, 12'b0, coord};
    endfunction

endpackage

// File: rtl/cpu_req_scheduler_if.sv
// rtl/cpu_req_scheduler_if.sv - requester and CPU-side signals of the scheduler
interface cpu_req_scheduler_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] new_req;
    logic [NUM_LANES-1:0] new_ack;
    logic                 chk_req;
    logic [9:0]           chk_coord;
    logic                 chk_ack;
    logic [31:0]          result;
    logic [31:0]          cpu_insn;
    logic                 cpu_insn_valid;
    logic [4:0]           cpu_rd_reg;
    logic                 cpu_rd_en;
    logic [31:0]          cpu_rd_data;
    logic                 busy;

    modport master (
        input  new_req, chk_req, chk_coord, cpu_rd_data,
        output new_ack, chk_ack, result, cpu_insn, cpu_insn_valid, cpu_rd_reg, cpu_rd_en, busy
    );

    modport slave (
        output new_req, chk_req, chk_coord, cpu_rd_data,
        input  new_ack, chk_ack, result, cpu_insn, cpu_insn_valid, cpu_rd_reg, cpu_rd_en, busy
    );
endinterface

// File: rtl/cpu_req_scheduler_rr_arbiter.sv
// rtl/cpu_req_scheduler_rr_arbiter.sv - combinational round-robin lane picker
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          any_o
);
    logic [N-1:0] eligible;
    int           idx;

    // Scan from the farthest offset down so the lane closest to the pointer wins.
    always_comb begin
        eligible = req_i & ~mask_i;
        any_o    = |eligible;
        grant_o  = '0;
        idx      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (eligible[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_req_scheduler.sv
// rtl/cpu_req_scheduler.sv - serialises lane and key-check requests onto the shared game CPU
module cpu_req_scheduler
    import cpu_sched_pkg::*;
#(
    parameter int          NUM_LANES     = 4,
    parameter int          LATENCY       = 6,
    parameter logic [31:0] INSN_NEW_NOTE = INSN_NEW_NOTE_DEF,
    parameter logic [9:0]  CHK_OP        = CHK_OP_DEF,
    parameter logic [4:0]  NEW_RD_REG    = NEW_RD_REG_DEF,
    parameter logic [4:0]  CHK_RD_REG    = CHK_RD_REG_DEF
) (
    input logic            clk,
    input logic            reset,
    cpu_req_scheduler_if.master bus
);
    localparam int PW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e               state_q, state_d;
    logic                 chk_pend_q, chk_pend_d;
    logic [9:0]           coord_q, coord_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 last_chk_q, last_chk_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_LANES-1:0] gnt_q, gnt_d;
    logic                 is_chk_q, is_chk_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          insn_q, insn_d;
    logic [31:0]          result_q, result_d;

    logic [NUM_LANES-1:0] arb_grant;
    logic                 arb_any;
    int                   lane_idx;

    rr_arbiter #(.N(NUM_LANES), .PW(PW)) u_arb (
        .req_i   (bus.new_req),
        .mask_i  (mask_q),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        lane_idx = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (gnt_q[k]) lane_idx = k;
        end
    end

    always_comb begin
        state_d    = state_q;
        chk_pend_d = chk_pend_q;
        coord_d    = coord_q;
        ptr_d      = ptr_q;
        last_chk_d = last_chk_q;
        mask_d     = mask_q;
        gnt_d      = gnt_q;
        is_chk_d   = is_chk_q;
        cnt_d      = cnt_q;
        insn_d     = insn_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                // A pending check yields to lanes only when it was served last.
                if (chk_pend_q && (!arb_any || !last_chk_q)) begin
                    is_chk_d   = 1'b1;
                    gnt_d      = '0;
                    insn_d     = chk_insn(CHK_OP, coord_q);
                    chk_pend_d = 1'b0;
                    state_d    = ST_ISSUE;
                end else if (arb_any) begin
                    is_chk_d = 1'b0;
                    gnt_d    = arb_grant;
                    insn_d   = INSN_NEW_NOTE;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(LATENCY);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) state_d = ST_READ;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_READ: begin
                result_d = bus.cpu_rd_data;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                last_chk_d = is_chk_q;
                if (!is_chk_q) begin
                    ptr_d  = PW'((lane_idx + 1) % NUM_LANES);
                    mask_d = gnt_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Key presses are captured in every state; the latest press wins.
        if (bus.chk_req) begin
            chk_pend_d = 1'b1;
            coord_d    = bus.chk_coord;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            chk_pend_q <= 1'b0;
            coord_q    <= '0;
            ptr_q      <= '0;
            last_chk_q <= 1'b0;
            mask_q     <= '0;
            gnt_q      <= '0;
            is_chk_q   <= 1'b0;
            cnt_q      <= '0;
            insn_q     <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            chk_pend_q <= chk_pend_d;
            coord_q    <= coord_d;
            ptr_q      <= ptr_d;
            last_chk_q <= last_chk_d;
            mask_q     <= mask_d;
            gnt_q      <= gnt_d;
            is_chk_q   <= is_chk_d;
            cnt_q      <= cnt_d;
            insn_q     <= insn_d;
            result_q   <= result_d;
        end
    end

    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.cpu_insn_valid = (state_q == ST_ISSUE);
    assign bus.cpu_rd_en      = (state_q == ST_READ);
    assign bus.cpu_rd_reg     = (state_q == ST_READ) ? (is_chk_q ? CHK_RD_REG : NEW_RD_REG) : 5'd0;
    assign bus.new_ack        = (state_q == ST_RESP && !is_chk_q) ? gnt_q : '0;
    assign bus.chk_ack        = (state_q == ST_RESP) && is_chk_q;
    assign bus.cpu_insn       = insn_q;
    assign bus.result         = result_q;

endmodule

// File: tb/tb_cpu_req_scheduler.sv
// tb/tb_cpu_req_scheduler.sv - randomized and directed bench with a timeline reference model
module tb_cpu_req_scheduler;
    import cpu_sched_pkg::*;

    localparam int N       = 4;
    localparam int LAT     = 6;
    localparam int ACK_AGE = LAT + 3;
    localparam int CHK_ID  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_req_scheduler_if #(.NUM_LANES(N)) bus ();
    logic [31:0] rf [32];
    assign bus.cpu_rd_data = rf[bus.cpu_rd_reg];

    cpu_req_scheduler #(.NUM_LANES(N), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    // Reference model: m_age counts cycles since the grant edge (0 = free).
    bit          m_pend;
    logic [9:0]  m_coord;
    bit          m_last_chk;
    int          m_ptr;
    logic [N-1:0] m_mask;
    int          m_age;
    bit          m_is_chk;
    int          m_lane;
    logic [31:0] m_insn;
    logic [31:0] m_result;

    logic [N-1:0] lanes;
    bit           rand_rf;
    int           ack_id[$];
    int           ack_step[$];
    logic [31:0]  vinsn[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_coord = '0; m_last_chk = 0; m_ptr = 0; m_mask = '0;
        m_age = 0; m_is_chk = 0; m_lane = 0; m_insn = '0; m_result = '0;
    endtask

    task automatic clear_logs();
        ack_id.delete(); ack_step.delete(); vinsn.delete();
    endtask

    task automatic step(input logic rstn, input logic cr, input logic [9:0] cc);
        logic [N-1:0] e_ack;
        logic [N-1:0] elig;
        logic         e_rd;
        bit           found;
        e_ack = (m_age == ACK_AGE && !m_is_chk) ? N'(1 << m_lane) : '0;
        e_rd  = (m_age == LAT + 2);
        check_eq("busy",     32'(bus.busy),           32'(m_age != 0));
        check_eq("insn_vld", 32'(bus.cpu_insn_valid), 32'(m_age == 1));
        check_eq("rd_en",    32'(bus.cpu_rd_en),      32'(e_rd));
        check_eq("rd_reg",   32'(bus.cpu_rd_reg),     e_rd ? (m_is_chk ? 32'd2 : 32'd1) : 32'd0);
        check_eq("new_ack",  32'(bus.new_ack),        32'(e_ack));
        check_eq("chk_ack",  32'(bus.chk_ack),        32'(m_age == ACK_AGE && m_is_chk));
        check_eq("cpu_insn", bus.cpu_insn,            m_insn);
        check_eq("result",   bus.result,              m_result);

        for (int k = 0; k < N; k++) begin
            if (bus.new_ack[k]) begin ack_id.push_back(k); ack_step.push_back(step_no); end
        end
        if (bus.chk_ack) begin ack_id.push_back(CHK_ID); ack_step.push_back(step_no); end
        if (bus.cpu_insn_valid) vinsn.push_back(bus.cpu_insn);
        lanes = lanes & ~bus.new_ack;

        reset         = rstn;
        bus.new_req   = lanes;
        bus.chk_req   = cr;
        bus.chk_coord = cc;
        if (rand_rf) begin rf[1] = $urandom; rf[2] = $urandom; end

        if (!rstn) begin
            model_reset();
        end else begin
            if (m_age == 0) begin
                elig   = lanes & ~m_mask;
                m_mask = '0;
                if (m_pend && (elig == 0 || !m_last_chk)) begin
                    m_is_chk = 1; m_insn = {CHK_OP_DEF, 12'b0, m_coord}; m_pend = 0; m_age = 1;
                end else if (elig != 0) begin
                    found = 0;
                    for (int i = 0; i < N; i++) begin
                        if (!found && elig[(m_ptr + i) % N]) begin found = 1; m_lane = (m_ptr + i) % N; end
                    end
                    m_is_chk = 0; m_insn = INSN_NEW_NOTE_DEF; m_age = 1;
                end
            end else if (m_age == ACK_AGE) begin
                m_last_chk = m_is_chk;
                if (!m_is_chk) begin m_ptr = (m_lane + 1) % N; m_mask = N'(1 << m_lane); end
                m_age = 0;
            end else begin
                if (m_age == LAT + 2) m_result = rf[m_is_chk ? 2 : 1];
                m_age++;
            end
            if (cr) begin m_pend = 1; m_coord = cc; end
        end
        step_no++;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int presses;
        int nchk;
        logic [31:0] chk_val;
        logic [9:0]  rc;
        logic        rr;
        logic        rcr;

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h2; rf[2] = 32'h1; rand_rf = 0;
        lanes = '0;
        reset = 1'b0; bus.new_req = '0; bus.chk_req = 1'b0; bus.chk_coord = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // single lane
        clear_logs(); lanes = 4'b0100; s0 = step_no;
        repeat (12) step(1, 0, 0);
        check_eq("p1_acks", 32'(ack_id.size()), 32'd1);
        if (ack_id.size() > 0) begin
            check_eq("p1_lane", 32'(ack_id[0]), 32'd2);
            check_eq("p1_lat",  32'(ack_step[0] - s0), 32'd9);
        end
        if (vinsn.size() > 0) check_eq("p1_insn", vinsn[0], 32'hF8400000);
        check_eq("p1_result", bus.result, 32'h2);

        // single check
        clear_logs(); s0 = step_no;
        step(1, 1, 10'd300);
        repeat (12) step(1, 0, 0);
        check_eq("p2_acks", 32'(ack_id.size()), 32'd1);
        if (ack_id.size() > 0) check_eq("p2_lat", 32'(ack_step[0] - s0), 32'd10);
        if (vinsn.size() > 0) check_eq("p2_insn", vinsn[0], 32'hF080012C);
        check_eq("p2_result", bus.result, 32'h1);

        // round robin from reset pointer
        step(0, 0, 0);
        clear_logs(); lanes = 4'b1111;
        repeat (45) step(1, 0, 0);
        check_eq("rr_acks", 32'(ack_id.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_id.size()) check_eq("rr_order", 32'(ack_id[i]), 32'(i));
            if (i > 0 && i < ack_id.size()) check_eq("rr_gap", 32'(ack_step[i] - ack_step[i-1]), 32'd10);
        end

        // check/lane contention
        clear_logs(); lanes = '0;
        step(1, 1, 10'd50);
        lanes = 4'b0011; presses = 1;
        for (int c = 0; c < 48; c++) begin
            rcr = (presses == 1 && ack_id.size() == 1);
            if (rcr) presses = 2;
            step(1, rcr, 10'd60);
        end
        check_eq("ct_acks", 32'(ack_id.size()), 32'd4);
        if (ack_id.size() == 4) begin
            check_eq("ct_0", 32'(ack_id[0]), 32'(CHK_ID));
            check_eq("ct_1", 32'(ack_id[1]), 32'd0);
            check_eq("ct_2", 32'(ack_id[2]), 32'(CHK_ID));
            check_eq("ct_3", 32'(ack_id[3]), 32'd1);
        end

        // overwrite of a pending check
        clear_logs(); lanes = 4'b0001;
        repeat (2) step(1, 0, 0);
        step(1, 1, 10'd100);
        repeat (2) step(1, 0, 0);
        step(1, 1, 10'd200);
        repeat (30) step(1, 0, 0);
        nchk = 0; chk_val = '0;
        foreach (vinsn[i]) if (vinsn[i][31:22] == CHK_OP_DEF) begin nchk++; chk_val = vinsn[i]; end
        check_eq("ow_count", 32'(nchk), 32'd1);
        check_eq("ow_insn", chk_val, 32'hF08000C8);

        // reset in WAIT abandons the service
        clear_logs(); lanes = 4'b0101;
        repeat (4) step(1, 0, 0);
        step(0, 0, 0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_insn", bus.cpu_insn, 32'd0);
        repeat (25) step(1, 0, 0);
        check_eq("rst_acks", 32'(ack_id.size()), 32'd2);
        if (ack_id.size() > 1) begin
            check_eq("rst_first", 32'(ack_id[0]), 32'd0);
            check_eq("rst_second", 32'(ack_id[1]), 32'd2);
        end

        // randomized traffic
        rand_rf = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!lanes[k] && $urandom_range(3) == 0) lanes[k] = 1'b1;
                else if (lanes[k] && $urandom_range(40) == 0) lanes[k] = 1'b0;
            end
            rcr = ($urandom_range(15) == 0);
            rc  = 10'($urandom);
            rr  = ($urandom_range(299) != 0);
            step(rr, rcr, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_req_scheduler.md
Name: cpu_req_scheduler

Overview:
- Shares the single game CPU (Wrapper) between two requester classes: the NUM_LANES falling-note lanes, which need a new note value, and the keyboard path, which needs a proximity check on the lowest note.
- Serialises requests, builds and issues the instruction, and waits a fixed pipeline latency.
- Reads the result register and returns the value to the granted requester with a one-cycle ack.
- Replaces ad-hoc cycle countdowns in the top-level game controller.

Parameters:
- NUM_LANES, 4, number of note lanes issuing new-note requests.
- LATENCY, 6, cycles from instruction strobe until the result register is readable (minimum 1).
- INSN_NEW_NOTE, 32'hF8400000, fixed new-note instruction.
- CHK_OP, 10'b1111000010, upper 10 bits of the check instruction.
- NEW_RD_REG, 5'd1, register holding the new-note result.
- CHK_RD_REG, 5'd2, register holding the check result.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- new_req  in  NUM_LANES  per-lane level request; held until that lane's new_ack.
- new_ack  out  NUM_LANES  one-hot one-cycle pulse; result is valid that cycle.
- chk_req  in  1  one-cycle pulse on a key press.
- chk_coord  in  10  y coordinate of the lowest note, sampled with chk_req.
- chk_ack  out  1  one-cycle pulse; result is valid that cycle.
- result  out  32  last value read from the CPU; held until the next response.
- cpu_insn  out  32  instruction to the CPU.
- cpu_insn_valid  out  1  one-cycle instruction strobe.
- cpu_rd_reg  out  5  register index to read.
- cpu_rd_en  out  1  read enable.
- cpu_rd_data  in  32  register read data; combinationally valid while cpu_rd_en=1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE; all outputs 0; cpu_insn=0.
  - chk pending flag, stored coord, round-robin pointer (lane 0), last_was_chk and ack mask all cleared.
  - Applies mid-operation: any in-flight request is abandoned, no ack is produced, and requesters must re-request.
- Check capture (every cycle, independent of state):
  - chk_req=1 sets chk_pend and stores chk_coord.
  - A pulse while already pending overwrites the coord; the latest press wins and only one check is serviced.
  - A pulse while a check is in service creates a new pending entry.
- FSM states: IDLE, ISSUE, WAIT, READ, RESP.
  - IDLE:
    - If chk_pend and no eligible lane is requesting, grant the check.
    - If no check is pending, grant a lane.
    - If both are present: grant the check, unless last_was_chk=1, in which case grant a lane. Checks and lanes therefore alternate under contention.
    - Lane choice is round-robin starting at the pointer. An eligible lane has new_req=1 and is not masked.
    - On grant, latch the requester id and build cpu_insn:
      - Lane: INSN_NEW_NOTE.
      - Check: {CHK_OP, 12'b0, coord}. chk_pend clears in this cycle unless a new chk_req arrives in the same cycle.
    - Go to ISSUE.
  - ISSUE: cpu_insn_valid=1 for exactly one cycle; load counter=LATENCY; go to WAIT.
  - WAIT: decrement the counter each cycle; after LATENCY cycles go to READ.
  - READ: cpu_rd_en=1; cpu_rd_reg=NEW_RD_REG or CHK_RD_REG; capture cpu_rd_data into result at the clock edge; go to RESP.
  - RESP:
    - Pulse new_ack[k] or chk_ack.
    - Update last_was_chk.
    - Lane grant: pointer=(k+1) mod NUM_LANES, and lane k is masked for the next IDLE cycle so its held request is not re-served.
    - Go to IDLE.
- Latency:
  - A request sampled in IDLE at cycle 0 produces ISSUE at cycle 1 and ack at cycle LATENCY+3 (9 with defaults).
  - Throughput is one request per LATENCY+4 cycles.
- A lane deasserting new_req before grant cancels its request; deasserting after grant does not abort the service.
- cpu_insn holds its value from ISSUE until the next grant.

Decomposition:
- Package cpu_sched_pkg:
  - state enum.
  - INSN_NEW_NOTE, CHK_OP, NEW_RD_REG and CHK_RD_REG defaults.
  - Key scan-code constants (8'h1c, 8'h1b, 8'h23, 8'h2b) shared with the top level.
- Sub-module rr_arbiter: combinational NUM_LANES round-robin picker.
  - Inputs: req, mask, pointer.
  - Outputs: one-hot grant and any.

Test Plan:
- Single lane: new_req=4'b0100, CPU model returns 32'h2 in r1 → one cpu_insn_valid with cpu_insn=32'hF8400000; new_ack=4'b0100 exactly 9 cycles after the request is sampled; result=32'h2.
- Check: chk_req pulse with chk_coord=10'd300, r2=1 → cpu_insn=32'hF0800000 | 300 (= 32'hF080012C); chk_ack at cycle 9; result=1; cpu_rd_reg=2 during READ.
- Round-robin: new_req=4'b1111 held, each lane deasserting after its ack → grant order 0,1,2,3; no lane is served twice; a gap of exactly 10 cycles between acks.
- Contention: chk_pend set and new_req=4'b0011 held → order chk, lane0, chk (after a re-press), lane1; no lane starves.
- Overwrite: two chk_req pulses (coord 100, then 200) while busy with a lane → exactly one check is issued, carrying coord 200.
- Reset: reset=0 during WAIT → next cycle busy=0, no ack fires, cpu_insn=0; after release a held new_req is re-served from lane 0.
